// File: rtl/silife_max7219_chain.sv
// rtl/silife_max7219_chain.sv - daisy-chained MAX7219 8x8 matrix grid driver with SPI shifter
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   i_enable                     display on; falling edge shuts the chain down cleanly
//   i_cells [WIDTH]              cells of grid row o_row_select (valid one clk after it changes)
//   i_brightness [4]             intensity; changes while idle are sent as a broadcast
//   i_reverse_columns            bit-reverse every data byte
//   i_serpentine                 odd device-rows mounted rotated 180 degrees
//   i_frame                      frame request (pulse or level), coalesced into one pending flag
//   o_cs, o_sck, o_mosi          SPI to the chain (cs active low, sck idles low)
//   o_busy                       high unless OFF, or IDLE with nothing pending
//   o_row_select [ROW_BITS]      grid row being fetched
//   o_frame_done                 one-clk pulse when a frame completes
module silife_max7219_chain #(
    parameter int SEG_COLS = 4,
    parameter int SEG_ROWS = 4,
    parameter int SCK_DIV  = 2,
    localparam int WIDTH    = 8 * SEG_COLS,
    localparam int HEIGHT   = 8 * SEG_ROWS,
    localparam int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_enable,
    input  logic [WIDTH-1:0]    i_cells,
    input  logic [3:0]          i_brightness,
    input  logic                i_reverse_columns,
    input  logic                i_serpentine,
    input  logic                i_frame,
    output logic                o_cs,
    output logic                o_sck,
    output logic                o_mosi,
    output logic                o_busy,
    output logic [ROW_BITS-1:0] o_row_select,
    output logic                o_frame_done
);

    localparam int SR_BITS  = (SEG_ROWS > 1) ? $clog2(SEG_ROWS) : 1;
    localparam int SC_BITS  = (SEG_COLS > 1) ? $clog2(SEG_COLS) : 1;
    localparam int DIV_BITS = $clog2(2 * SCK_DIV);

    localparam logic [SR_BITS-1:0]  SR_MAX   = SR_BITS'(SEG_ROWS - 1);
    localparam logic [SC_BITS-1:0]  SC_MAX   = SC_BITS'(SEG_COLS - 1);
    localparam logic [DIV_BITS-1:0] HALF_MAX = DIV_BITS'(SCK_DIV - 1);
    localparam logic [DIV_BITS-1:0] GAP_MAX  = DIV_BITS'(2 * SCK_DIV - 1);

    typedef enum logic [2:0] {
        S_OFF, S_INIT, S_DATA, S_WAKE, S_IDLE, S_BRIGHT, S_SHUT
    } state_t;

    typedef enum logic [2:0] {
        P_NONE, P_FETCH, P_SAMPLE, P_SHIFT, P_GAP
    } phase_t;

    state_t               state, state_next;
    phase_t               phase;
    logic                 pending;
    logic                 first_frame;
    logic                 frame_done;
    logic                 sck_high;
    logic [DIV_BITS-1:0]  half_cnt;
    logic [3:0]           bit_cnt;
    logic [SR_BITS-1:0]   dev_row;
    logic [SC_BITS-1:0]   dev_col;
    logic [3:0]           digit;
    logic [1:0]           init_idx;
    logic [15:0]          shift_reg;
    logic [ROW_BITS-1:0]  row_sel;
    logic [3:0]           bright_sent;

    logic                 tx_end;
    logic                 tx_start;
    logic                 enter_data;
    logic                 last_dev;
    logic                 bright_load;
    logic [3:0]           start_digit;
    logic                 rot;
    logic [SC_BITS-1:0]   src_col;
    logic [7:0]           data_byte;
    logic [15:0]          tx_word;

    function automatic logic is_tx(input state_t s);
        return !(s == S_OFF || s == S_IDLE);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Grid row for digit d of device-row r; rotated device-rows read their rows bottom-up.
    function automatic logic [ROW_BITS-1:0] row_of(input logic [SR_BITS-1:0] r,
                                                    input logic [3:0] d,
                                                    input logic serp);
        logic [2:0] off;
        off = (serp && r[0]) ? 3'(4'd8 - d) : 3'(d - 4'd1);
        return ROW_BITS'({r, off});
    endfunction

    assign tx_end     = (phase == P_GAP) && (half_cnt == GAP_MAX);
    // A new transaction begins after an OFF/IDLE decision, or back-to-back after the gap.
    assign tx_start   = is_tx(state_next) && (!is_tx(state) || tx_end);
    assign enter_data = (state != S_DATA) && (state_next == S_DATA);
    assign last_dev   = (dev_row == '0) && (dev_col == '0);
    assign start_digit = (state == S_DATA) ? digit + 4'd1 : 4'd1;
    assign bright_load = (phase == P_FETCH) && (dev_row == SR_MAX) && (dev_col == SC_MAX) &&
                         ((state == S_INIT && init_idx == 2'd3) || state == S_BRIGHT);

    // Word for the device currently addressed.
    always_comb begin
        rot       = i_serpentine && dev_row[0];
        src_col   = rot ? (SC_MAX - dev_col) : dev_col;
        data_byte = i_cells[{src_col, 3'b000} +: 8];
        if (rot) data_byte = rev8(data_byte);
        if (i_reverse_columns) data_byte = rev8(data_byte);
        tx_word = 16'h0000;
        case (state)
            S_INIT: begin
                case (init_idx)
                    2'd0:    tx_word = 16'h0F00;
                    2'd1:    tx_word = 16'h0B07;
                    2'd2:    tx_word = 16'h0900;
                    default: tx_word = {12'h0A0, bright_sent};
                endcase
            end
            S_DATA:   tx_word = {4'h0, digit, data_byte};
            S_WAKE:   tx_word = 16'h0C01;
            S_BRIGHT: tx_word = {12'h0A0, bright_sent};
            S_SHUT:   tx_word = 16'h0C00;
            default:  tx_word = 16'h0000;
        endcase
    end

    // State register plus request/flag bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_OFF;
            pending     <= 1'b0;
            first_frame <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state <= state_next;
            // A request arriving in the consuming cycle is newer, so it survives.
            if (i_frame)
                pending <= 1'b1;
            else if (enter_data)
                pending <= 1'b0;
            if (state == S_INIT && state_next == S_DATA)
                first_frame <= 1'b1;
            else if (state == S_DATA && state_next != S_DATA)
                first_frame <= 1'b0;
            frame_done <= (state == S_DATA || state == S_WAKE) && (state_next == S_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_OFF:
                if (i_enable) state_next = S_INIT;
            S_IDLE: begin
                if (!i_enable)                        state_next = S_SHUT;
                else if (i_brightness != bright_sent) state_next = S_BRIGHT;
                else if (pending)                     state_next = S_DATA;
            end
            S_INIT:
                if (tx_end) begin
                    if (!i_enable)              state_next = S_SHUT;
                    else if (init_idx == 2'd3)  state_next = S_DATA;
                end
            S_DATA:
                if (tx_end) begin
                    if (!i_enable)            state_next = S_SHUT;
                    else if (digit == 4'd8)   state_next = first_frame ? S_WAKE : S_IDLE;
                end
            S_WAKE:   if (tx_end) state_next = S_IDLE;
            S_BRIGHT: if (tx_end) state_next = S_IDLE;
            S_SHUT:   if (tx_end) state_next = S_OFF;
            default:  state_next = S_OFF;
        endcase
    end

    // Outputs.
    always_comb begin
        o_cs         = !(phase == P_FETCH || phase == P_SAMPLE || phase == P_SHIFT);
        o_sck        = (phase == P_SHIFT) && sck_high;
        o_mosi       = (phase == P_SHIFT) && shift_reg[15];
        o_busy       = !(state == S_OFF || (state == S_IDLE && !pending));
        o_row_select = row_sel;
        o_frame_done = frame_done;
    end

    // Word sequencer and SPI shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= P_NONE;
            sck_high    <= 1'b0;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            dev_row     <= '0;
            dev_col     <= '0;
            digit       <= '0;
            init_idx    <= '0;
            shift_reg   <= '0;
            row_sel     <= '0;
            bright_sent <= '0;
        end else if (tx_start) begin
            phase    <= P_FETCH;
            sck_high <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            dev_row  <= SR_MAX;
            dev_col  <= SC_MAX;
            if (state_next == S_INIT)
                init_idx <= (state == S_INIT) ? init_idx + 2'd1 : 2'd0;
            if (state_next == S_DATA) begin
                digit   <= start_digit;
                row_sel <= row_of(SR_MAX, start_digit, i_serpentine);
            end
        end else begin
            case (phase)
                P_FETCH: begin
                    phase <= P_SAMPLE;
                    if (bright_load) bright_sent <= i_brightness;
                end
                P_SAMPLE: begin
                    shift_reg <= tx_word;
                    phase     <= P_SHIFT;
                end
                P_SHIFT: begin
                    if (half_cnt != HALF_MAX) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!sck_high) begin
                            sck_high <= 1'b1;
                        end else begin
                            sck_high <= 1'b0;
                            if (bit_cnt != 4'd15) begin
                                bit_cnt   <= bit_cnt + 4'd1;
                                shift_reg <= {shift_reg[14:0], 1'b0};
                            end else begin
                                bit_cnt <= '0;
                                if (last_dev) begin
                                    phase <= P_GAP;
                                end else begin
                                    phase <= P_FETCH;
                                    if (dev_col == '0) begin
                                        dev_col <= SC_MAX;
                                        dev_row <= dev_row - 1'b1;
                                        if (state == S_DATA)
                                            row_sel <= row_of(dev_row - 1'b1, digit, i_serpentine);
                                    end else begin
                                        dev_col <= dev_col - 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                P_GAP: begin
                    if (half_cnt == GAP_MAX) begin
                        half_cnt <= '0;
                        phase    <= P_NONE;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: phase <= P_NONE;
            endcase
        end
    end

endmodule
